// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, picks the next fetch address from the
// sequential/branch/jump/jr/vector sources, runs the variable-latency imem
// handshake and presents {instruction, PC+4} to the IF/ID register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic [2:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_addr,
    input  logic [31:0] jump_pc_plus_4,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc_plus_4,
    output logic        o_fetch_stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2,
        ST_HAVE = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] req_addr_r;
    logic [31:0] inst_buf_r;

    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] seq_next_s;
    logic        deliver_s;
    logic        have_s;

    // Supervisor bit 31 is kept; only the low 31 bits advance and wrap.
    function automatic logic [31:0] seq_next(input logic [31:0] addr);
        return {addr[31], addr[30:0] + 31'd4};
    endfunction

    // Decode the redirect request and its target address.
    always_comb begin
        redirect_s = 1'b0;
        target_s   = seq_next_s;
        case (pc_src)
            3'd1: begin
                redirect_s = pc_write;
                target_s   = branch_target;
            end
            3'd2: begin
                redirect_s = pc_write;
                target_s   = {jump_pc_plus_4[31:28], jump_addr, 2'b00};
            end
            3'd3: begin
                redirect_s = pc_write;
                target_s   = jr_target;
            end
            3'd4: begin
                redirect_s = pc_write;
                target_s   = ILLOP_PC;
            end
            3'd5: begin
                redirect_s = pc_write;
                target_s   = XADR_PC;
            end
            default: begin
                redirect_s = 1'b0;
                target_s   = seq_next_s;
            end
        endcase
    end

    // Output view of the fetch: request handshake and the presented instruction.
    always_comb begin
        seq_next_s  = seq_next(req_addr_r);
        deliver_s   = (state_r == ST_REQ) && imem_ready;
        have_s      = (state_r == ST_HAVE);
        imem_req    = (state_r == ST_REQ) || (state_r == ST_DROP);
        imem_addr   = req_addr_r;
        o_pc_plus_4 = seq_next_s;
        if (deliver_s) begin
            o_instruction = imem_rdata;
        end else if (have_s) begin
            o_instruction = inst_buf_r;
        end else begin
            o_instruction = 32'd0;
        end
        o_fetch_stall = ~(deliver_s | have_s);
    end

    // Fetch FSM with PC, request address and instruction buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            req_addr_r <= RESET_PC;
            inst_buf_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ready) begin
                        if (redirect_s) begin
                            pc_r       <= target_s;
                            req_addr_r <= target_s;
                        end else if (pc_write) begin
                            pc_r       <= seq_next_s;
                            req_addr_r <= seq_next_s;
                        end else begin
                            inst_buf_r <= imem_rdata;
                            state_r    <= ST_HAVE;
                        end
                    end else if (redirect_s) begin
                        // The in-flight read cannot be cancelled; discard it later.
                        pc_r    <= target_s;
                        state_r <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (imem_ready) begin
                        if (redirect_s) begin
                            pc_r       <= target_s;
                            req_addr_r <= target_s;
                        end else begin
                            req_addr_r <= pc_r;
                        end
                        state_r <= ST_REQ;
                    end else if (redirect_s) begin
                        pc_r <= target_s;
                    end
                end
                ST_HAVE: begin
                    if (redirect_s) begin
                        pc_r       <= target_s;
                        req_addr_r <= target_s;
                        state_r    <= ST_REQ;
                    end else if (pc_write) begin
                        pc_r       <= seq_next_s;
                        req_addr_r <= seq_next_s;
                        state_r    <= ST_REQ;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, reset-mid-drop sequence,
// then randomized traffic against a transaction-level fetch model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic [2:0]  pc_src;
    logic [31:0] branch_target;
    logic [25:0] jump_addr;
    logic [31:0] jump_pc_plus_4;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_plus_4;
    logic        o_fetch_stall;

    int checks = 0;
    int errors = 0;

    if_fetch_stage dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .pc_src(pc_src),
        .branch_target(branch_target), .jump_addr(jump_addr),
        .jump_pc_plus_4(jump_pc_plus_4), .jr_target(jr_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .o_instruction(o_instruction),
        .o_pc_plus_4(o_pc_plus_4), .o_fetch_stall(o_fetch_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pw;
        logic [2:0]  src;
        logic        rdy;
        logic [31:0] rdata;
        logic [31:0] tgt;
        logic [31:0] jpc;
        logic [25:0] jaddr;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pp4;
        logic [31:0] e_instr;
        logic        e_stall;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic pw, input logic [2:0] src, input logic rdy,
                       input logic [31:0] rdata, input logic [31:0] tgt,
                       input logic [31:0] jpc, input logic [25:0] jaddr,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_pp4, input logic [31:0] e_instr,
                       input logic e_stall);
        vec_t v;
        v.pw = pw; v.src = src; v.rdy = rdy; v.rdata = rdata; v.tgt = tgt;
        v.jpc = jpc; v.jaddr = jaddr; v.e_req = e_req; v.e_addr = e_addr;
        v.e_pp4 = e_pp4; v.e_instr = e_instr; v.e_stall = e_stall;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic [31:0] e_pp4, input logic [31:0] e_instr,
                           input logic e_stall);
        chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
        chk({tag, ".imem_addr"}, imem_addr, e_addr);
        chk({tag, ".pc_plus_4"}, o_pc_plus_4, e_pp4);
        chk({tag, ".instr"}, o_instruction, e_instr);
        chk({tag, ".stall"}, {31'd0, o_fetch_stall}, {31'd0, e_stall});
    endtask

    // ---------------- reference model (fetch transactions) ----------------
    bit          m_booting;  // first cycle after reset: nothing issued yet
    bit          m_busy;     // a read is in flight
    bit          m_stale;    // the in-flight read belongs to an abandoned path
    bit          m_held;     // an instruction is parked waiting for the pipe
    logic [31:0] m_addr;     // address of in-flight / presented fetch
    logic [31:0] m_pc;       // where the program wants to go next
    logic [31:0] m_buf;

    function automatic logic [31:0] plus4(input logic [31:0] a);
        logic [31:0] low;
        low = (a + 32'd4) & 32'h7FFF_FFFF;
        return (a & 32'h8000_0000) | low;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction

    function automatic bit is_redirect(input logic pw, input logic [2:0] src);
        return pw && (src >= 3'd1) && (src <= 3'd5);
    endfunction

    function automatic logic [31:0] tgt_of(input logic [2:0] src);
        if (src == 3'd1) return branch_target;
        if (src == 3'd2) return (jump_pc_plus_4 & 32'hF000_0000) | ({6'd0, jump_addr} << 2);
        if (src == 3'd3) return jr_target;
        if (src == 3'd4) return 32'h8000_0004;
        return 32'h8000_0008;
    endfunction

    task automatic model_reset();
        m_booting = 1'b1; m_busy = 1'b0; m_stale = 1'b0; m_held = 1'b0;
        m_addr = 32'h8000_0000; m_pc = 32'h8000_0000; m_buf = 32'd0;
    endtask

    task automatic model_check();
        bit got;
        logic [31:0] e_instr;
        got = m_busy && !m_stale && imem_ready;
        e_instr = got ? imem_rdata : (m_held ? m_buf : 32'd0);
        chk_all("rand", m_busy, m_addr, plus4(m_addr), e_instr, !(got || m_held));
    endtask

    task automatic model_step();
        bit rd;
        logic [31:0] t;
        rd = is_redirect(pc_write, pc_src);
        t = tgt_of(pc_src);
        if (m_booting) begin
            m_booting = 1'b0; m_busy = 1'b1;
        end else if (m_held) begin
            if (rd || pc_write) begin
                m_addr = rd ? t : plus4(m_addr); m_pc = m_addr;
                m_held = 1'b0; m_busy = 1'b1;
            end
        end else if (m_busy && !m_stale) begin
            if (imem_ready) begin
                if (rd || pc_write) begin
                    m_addr = rd ? t : plus4(m_addr); m_pc = m_addr;
                end else begin
                    m_held = 1'b1; m_buf = imem_rdata; m_busy = 1'b0;
                end
            end else if (rd) begin
                m_pc = t; m_stale = 1'b1;
            end
        end else if (m_busy && m_stale) begin
            if (rd) m_pc = t;
            if (imem_ready) begin
                m_addr = m_pc; m_stale = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b0; pc_write = 1'b0; pc_src = 3'd0; branch_target = 32'd0;
        jump_addr = 26'd0; jump_pc_plus_4 = 32'd0; jr_target = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;

        repeat (3) @(negedge clk);
        #1 chk_all("reset", 1'b0, 32'h8000_0000, 32'h8000_0004, 32'd0, 1'b1);

        // boot, wait states, hold, redirect while waiting, jump/vectors, wrap
        add(1,0,0,32'h0,0,0,0,        0,32'h8000_0000,32'h8000_0004,32'h0,1);
        add(1,0,1,32'hA000_0000,0,0,0,1,32'h8000_0000,32'h8000_0004,32'hA000_0000,0);
        add(1,0,1,32'hA000_0001,0,0,0,1,32'h8000_0004,32'h8000_0008,32'hA000_0001,0);
        add(1,0,1,32'hA000_0002,0,0,0,1,32'h8000_0008,32'h8000_000C,32'hA000_0002,0);
        for (int k = 0; k < 3; k++)
            add(1,0,0,32'hEEEE_EEEE,0,0,0,1,32'h8000_000C,32'h8000_0010,32'h0,1);
        add(1,0,1,32'hA000_0003,0,0,0,1,32'h8000_000C,32'h8000_0010,32'hA000_0003,0);
        add(0,0,1,32'hA000_0004,0,0,0,1,32'h8000_0010,32'h8000_0014,32'hA000_0004,0);
        for (int k = 0; k < 3; k++)
            add(0,0,0,32'hFFFF_FFFF,0,0,0,0,32'h8000_0010,32'h8000_0014,32'hA000_0004,0);
        add(1,0,0,32'hFFFF_FFFF,0,0,0,0,32'h8000_0010,32'h8000_0014,32'hA000_0004,0);
        add(1,3,0,32'h0,32'h0040_0020,0,0,1,32'h8000_0014,32'h8000_0018,32'h0,1);
        add(1,0,0,32'h0,0,0,0,        1,32'h8000_0014,32'h8000_0018,32'h0,1);
        add(1,0,1,32'hDEAD_BEEF,0,0,0,1,32'h8000_0014,32'h8000_0018,32'h0,1);
        add(1,2,1,32'hA000_0005,0,32'h8000_1234,26'h0000100,
            1,32'h0040_0020,32'h0040_0024,32'hA000_0005,0);
        add(1,4,1,32'hA000_0006,0,0,0,1,32'h8000_0400,32'h8000_0404,32'hA000_0006,0);
        add(1,5,1,32'hA000_0007,0,0,0,1,32'h8000_0004,32'h8000_0008,32'hA000_0007,0);
        add(1,7,1,32'hA000_0008,0,0,0,1,32'h8000_0008,32'h8000_000C,32'hA000_0008,0);
        add(1,1,1,32'hA000_0009,32'hFFFF_FFFC,0,0,1,32'h8000_000C,32'h8000_0010,32'hA000_0009,0);
        add(1,0,1,32'hA000_000A,0,0,0,1,32'hFFFF_FFFC,32'h8000_0000,32'hA000_000A,0);
        add(1,1,1,32'hA000_000B,32'h7FFF_FFFC,0,0,1,32'h8000_0000,32'h8000_0004,32'hA000_000B,0);
        add(1,0,1,32'hA000_000C,0,0,0,1,32'h7FFF_FFFC,32'h0000_0000,32'hA000_000C,0);
        add(1,0,0,32'h0,0,0,0,        1,32'h0000_0000,32'h0000_0004,32'h0,1);
        add(1,1,0,32'h0,32'h1234_5678,0,0,1,32'h0000_0000,32'h0000_0004,32'h0,1);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            if (i != 0) @(negedge clk);
            pc_write = vq[i].pw; pc_src = vq[i].src; imem_ready = vq[i].rdy;
            imem_rdata = vq[i].rdata; branch_target = vq[i].tgt; jr_target = vq[i].tgt;
            jump_pc_plus_4 = vq[i].jpc; jump_addr = vq[i].jaddr;
            #1 chk_all($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr,
                       vq[i].e_pp4, vq[i].e_instr, vq[i].e_stall);
        end

        // Reset lands while the DUT is in DROP; a late ready must be ignored.
        @(negedge clk);
        reset = 1'b0; imem_ready = 1'b0; pc_src = 3'd0;
        #1 chk_all("rst_drop", 1'b0, 32'h8000_0000, 32'h8000_0004, 32'd0, 1'b1);
        @(negedge clk);
        imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1 chk_all("rst_late", 1'b0, 32'h8000_0000, 32'h8000_0004, 32'd0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1 chk_all("idle_late", 1'b0, 32'h8000_0000, 32'h8000_0004, 32'd0, 1'b1);
        @(negedge clk);
        imem_ready = 1'b0;
        #1 chk_all("restart", 1'b1, 32'h8000_0000, 32'h8000_0004, 32'd0, 1'b1);

        // Randomized traffic against the model, starting from a fresh reset.
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        for (int n = 0; n < 4000; n++) begin
            bit zero_wait;
            bit do_rst;
            if (n != 0) @(negedge clk);
            zero_wait = ((n / 500) % 2) == 1;
            do_rst = ($urandom_range(0, 499) == 0);
            reset = do_rst ? 1'b0 : 1'b1;
            pc_write = ($urandom_range(0, 3) != 0);
            pc_src = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            branch_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            jr_target = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            jump_addr = 26'($urandom);
            jump_pc_plus_4 = $urandom;
            if (m_busy)
                imem_ready = zero_wait ? 1'b1 : ($urandom_range(0, 2) == 0);
            else
                imem_ready = ($urandom_range(0, 9) == 0);
            imem_rdata = m_busy ? mem_word(m_addr) : $urandom;
            #1;
            if (do_rst) begin
                model_reset();
                chk_all("rand_rst", 1'b0, 32'h8000_0000, 32'h8000_0004, 32'd0, 1'b1);
            end else begin
                model_check();
                model_step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
